bcd_frame_conv: RTL and testbench
=================================

// Module: bcd_frame_conv
// PURPOSE
//  Sequential double-dabble converter for a frame of L unsigned binary words into packed BCD
//  digit nibbles for the character-cell display path. The display nibbles feed the line
//  selector and font ROM. A start pulse (normally vsync) snapshots the input. Results commit
//  atomically at the end of the frame, so the display never shows a half-updated frame.
//  Generalises the fixed 10-bit/3-digit converter to any word width, digit count and word count.
//  Adds a busy/done handshake and per-word overflow flags.
// PARAMETERS
//  W  10  bits per input binary word (>=1)
//  D  4   BCD digits per output word; output word = 4*D bits
//  L  10  number of words per frame (>=1)
// PORTS
//  clk    in   1        clock
//  RSTn   in   1        asynchronous active-low reset
//  start  in   1        conversion request; sampled only in IDLE
//  bin    in   L*W      word i = bin[W*i +: W]
//  busy   out  1        high from cycle after accepted start until DONE inclusive
//  done   out  1        one-cycle pulse; dec/ovf hold new frame from this cycle
//  dec    out  L*4*D    word i = dec[4*D*i +: 4*D], digit k (k=0 LSD) = nibble k of word
//  ovf    out  L        ovf[i]=1 if word i >= 10**D (dec holds low D digits)
// BEHAVIOUR
//  Reset (async, RSTn=0): state=IDLE; busy=0, done=0, dec=0, ovf=0; all working regs cleared.
//  Reset mid-conversion aborts the conversion. The partial frame is discarded and never committed.
//  FSM:
//   IDLE : start=1 -> snapshot bin into shadow reg, widx<=0 -> LOAD. start=0 -> stay.
//   LOAD : sreg<=shadow word widx, work bcd<=0, bitcnt<=0, wovf<=0 -> SHIFT.
//   SHIFT: each nibble of bcd >=5 gets +3 (combinational), then {bcd,sreg} shifts left by 1.
//          A 1 shifted out of the bcd MSB sets wovf (sticky). bitcnt++. After W shifts -> STORE.
//   STORE: work buffer slot widx <= bcd, wovf bit widx <= wovf.
//          widx==L-1 -> DONE, else widx++ -> LOAD.
//   DONE : dec<=work buffer, ovf<=wovf buffer, done=1 (this cycle only) -> IDLE.
//  Latency: start sampled at edge 0 -> done high in the cycle after edge 1+L*(W+2).
//   For defaults this is edge 121.
//  start while busy is ignored (not queued). bin changes after the accepting edge do not
//   affect the result (snapshot).
//  start held high continuously restarts one cycle after each DONE (back-to-back frames).
//  dec/ovf change only in DONE; they are stable at all other times, including during busy.
//  Word order matches bin: word 0 at LSBs of both buses. No signed input support.
// CONFIGURATION
//  LZ_BLANK_EN defined: at commit, leading zero digits from digit D-1 down to digit 1 become
//   4'hF (blank glyph). Digit 0 is never blanked, so value 0 -> F..F0.
//   Blanking stops at the first nonzero digit. It is applied to the committed dec only.
//   ovf is unaffected, and an overflowed word is blanked by the same rule on its low D digits.
//  LZ_BLANK_EN undefined: digits are committed verbatim (leading zeros shown as 0).
//   No blanking logic is present.
// TESTING
//  1 Reset: RSTn=0 async mid-cycle -> busy=0, done=0, dec=0, ovf=0 immediately.
//  2 Defaults: words 0,1,9,10,99,100,999,1000,1023,512 and a start pulse.
//    Required: done exactly at edge 121.
//    Required dec words: 0000,0001,0009,0010,0099,0100,0999,1000,1023,0512 (hex).
//    Required: ovf=0.
//  3 D=3 instance with word0=1023, word1=999 -> dec word0=023 with ovf[0]=1;
//    dec word1=999 with ovf[1]=0.
//  4 start again at edge 50 while busy, and bin changed at edge 5 -> ignored.
//    Result equals the snapshot and done pulses once.
//  5 RSTn low at edge 60 -> abort and dec stays 0. A new start later completes with correct data.
//  6 LZ_BLANK_EN with words 0,7,40,1000 -> FFF0, FFF7, FF40, 1000. Without the macro -> 0000,0007,0040,1000.

Source files
------------

// File: rtl/bcd_frame_conv_if.sv
// Frame handshake bundle for bcd_frame_conv: start/bin in, busy/done/dec/ovf out.
interface bcd_frame_conv_if #(
   parameter int W = 10,
   parameter int D = 4,
   parameter int L = 10
);
   logic             start;
   logic [L*W-1:0]   bin;
   logic             busy;
   logic             done;
   logic [L*4*D-1:0] dec;
   logic [L-1:0]     ovf;

   modport master (output start, output bin,
                   input  busy, input done, input dec, input ovf);
   modport slave  (input  start, input bin,
                   output busy, output done, output dec, output ovf);
endinterface

// File: rtl/bcd_frame_conv.sv
// Sequential double-dabble conversion of a frame of L binary words into packed BCD, committed atomically.
// Optional leading-zero blanking at commit when LZ_BLANK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; snapshots bin on accept
// LOAD  | fetch shadow word widx into shift register, clear working BCD
// SHIFT | one add-3/shift step per cycle, W steps per word
// STORE | write word result and overflow flag into the work buffer
// DONE  | commit work buffer to dec/ovf, pulse done next cycle
module bcd_frame_conv #(
   parameter int W = 10,
   parameter int D = 4,
   parameter int L = 10
) (
   input  logic            clk,
   input  logic            RSTn,
   bcd_frame_conv_if.slave bus
);
   localparam int DW = 4*D;
   localparam int BW = $clog2(W+1);
   localparam int IW = (L > 1) ? $clog2(L) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;
   state_t state, state_nxt;

   logic [L*W-1:0]  shadow;
   logic [W-1:0]    sreg;
   logic [DW-1:0]   bcd;
   logic [DW-1:0]   bcd_adj;
   logic [BW-1:0]   bitcnt;
   logic [IW-1:0]   widx;
   logic            wovf;
   logic [L*DW-1:0] work;
   logic [L-1:0]    work_ovf;
   logic [L*DW-1:0] dec_commit;
   logic [L*DW-1:0] dec_r;
   logic [L-1:0]    ovf_r;
   logic            done_r;
   logic            last_bit;
   logic            last_word;

   assign last_bit  = (bitcnt == BW'(W-1));
   assign last_word = (widx == IW'(L-1));

   always_comb begin
      bcd_adj = bcd;
      for (int k = 0; k < D; k++) begin
         if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
   end

`ifdef LZ_BLANK_EN
   logic lead;

   // Digits above the first nonzero one become the blank glyph; digit 0 always shows.
   always_comb begin
      dec_commit = work;
      lead       = 1'b0;
      for (int i = 0; i < L; i++) begin
         lead = 1'b1;
         for (int k = D-1; k >= 1; k--) begin
            if (lead && (work[DW*i + 4*k +: 4] == 4'd0)) dec_commit[DW*i + 4*k +: 4] = 4'hF;
            else lead = 1'b0;
         end
      end
   end
`else
   assign dec_commit = work;
`endif

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = STORE;
         STORE:   state_nxt = last_word ? DONE : LOAD;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE) || done_r;
   end

   assign bus.done = done_r;
   assign bus.dec  = dec_r;
   assign bus.ovf  = ovf_r;

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         shadow   <= '0;
         sreg     <= '0;
         bcd      <= '0;
         bitcnt   <= '0;
         widx     <= '0;
         wovf     <= 1'b0;
         work     <= '0;
         work_ovf <= '0;
         dec_r    <= '0;
         ovf_r    <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  shadow <= bus.bin;
                  widx   <= '0;
               end
            end
            LOAD: begin
               sreg   <= shadow[W*widx +: W];
               bcd    <= '0;
               bitcnt <= '0;
               wovf   <= 1'b0;
            end
            SHIFT: begin
               // A carry out of the top digit is a multiple of 10**D; the low digits stay exact.
               bcd    <= {bcd_adj[DW-2:0], sreg[W-1]};
               sreg   <= sreg << 1;
               wovf   <= wovf | bcd_adj[DW-1];
               bitcnt <= bitcnt + BW'(1);
            end
            STORE: begin
               work[DW*widx +: DW] <= bcd;
               work_ovf[widx]      <= wovf;
               if (!last_word) widx <= widx + IW'(1);
            end
            DONE: begin
               dec_r  <= dec_commit;
               ovf_r  <= work_ovf;
               done_r <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_frame_conv.sv
// Randomized self-checking bench for bcd_frame_conv against a div/mod decimal reference model.
module tb_bcd_frame_conv;
   localparam int W    = 10;
   localparam int D    = 4;
   localparam int L    = 10;
   localparam int DW   = 4*D;
   localparam int LAT  = 1 + L*(W+2);
   localparam int D3   = 3;
   localparam int L3   = 2;
   localparam int DW3  = 4*D3;
   localparam int LAT3 = 1 + L3*(W+2);

   logic clk  = 1'b0;
   logic RSTn = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   bcd_frame_conv_if #(.W(W), .D(D),  .L(L))  bus_a ();
   bcd_frame_conv_if #(.W(W), .D(D3), .L(L3)) bus_b ();

   bcd_frame_conv #(.W(W), .D(D),  .L(L))  dut_a (.clk(clk), .RSTn(RSTn), .bus(bus_a.slave));
   bcd_frame_conv #(.W(W), .D(D3), .L(L3)) dut_b (.clk(clk), .RSTn(RSTn), .bus(bus_b.slave));

   logic [L*DW-1:0]   exp_dec;
   logic [L-1:0]      exp_ovf;
   logic [L3*DW3-1:0] exp_dec_b;
   logic [L3-1:0]     exp_ovf_b;
   int done_edge;
   int done_cnt;

   function automatic logic [31:0] ref_word(input int v, input int nd);
      logic [31:0] w;
      int          r;
      bit          lead;
      w = '0;
      r = v % (10**nd);
      for (int k = 0; k < nd; k++) begin
         w[4*k +: 4] = 4'(r % 10);
         r = r / 10;
      end
`ifdef LZ_BLANK_EN
      lead = 1'b1;
      for (int k = nd-1; k >= 1; k--) begin
         if (lead && w[4*k +: 4] == 4'd0) w[4*k +: 4] = 4'hF;
         else lead = 1'b0;
      end
`else
      lead = 1'b0;
`endif
      return w;
   endfunction

   task automatic build_exp(input logic [L*W-1:0] f);
      logic [31:0] t;
      int v;
      for (int i = 0; i < L; i++) begin
         v = int'(f[W*i +: W]);
         t = ref_word(v, D);
         exp_dec[DW*i +: DW] = t[DW-1:0];
         exp_ovf[i] = (v >= 10**D);
      end
   endtask

   task automatic build_exp_b(input logic [L3*W-1:0] f);
      logic [31:0] t;
      int v;
      for (int i = 0; i < L3; i++) begin
         v = int'(f[W*i +: W]);
         t = ref_word(v, D3);
         exp_dec_b[DW3*i +: DW3] = t[DW3-1:0];
         exp_ovf_b[i] = (v >= 10**D3);
      end
   endtask

   function automatic logic [L*W-1:0] rand_frame();
      logic [L*W-1:0] f;
      for (int i = 0; i < L; i++) f[W*i +: W] = W'($urandom_range(0, 1023));
      return f;
   endfunction

   task automatic kick_a(input logic [L*W-1:0] f);
      @(negedge clk);
      bus_a.bin   = f;
      bus_a.start = 1'b1;
      @(posedge clk);
      #1 bus_a.start = 1'b0;
   endtask

   task automatic wait_a(input int budget);
      done_edge = -1;
      done_cnt  = 0;
      for (int e = 1; e <= budget; e++) begin
         @(posedge clk);
         #1;
         if (bus_a.done === 1'b1) begin
            if (done_cnt == 0) done_edge = e;
            done_cnt++;
         end
      end
   endtask

   task automatic kick_b(input logic [L3*W-1:0] f);
      @(negedge clk);
      bus_b.bin   = f;
      bus_b.start = 1'b1;
      @(posedge clk);
      #1 bus_b.start = 1'b0;
   endtask

   task automatic wait_b(input int budget);
      done_edge = -1;
      done_cnt  = 0;
      for (int e = 1; e <= budget; e++) begin
         @(posedge clk);
         #1;
         if (bus_b.done === 1'b1) begin
            if (done_cnt == 0) done_edge = e;
            done_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      logic [L*W-1:0] f;
      #2;
      n_cmp++;
      if ({bus_a.busy, bus_a.done, bus_a.ovf} !== '0 || bus_a.dec !== '0) begin
         n_bad++;
         $display("FAIL reset_init: busy=%b done=%b dec=%h ovf=%h want all 0", bus_a.busy, bus_a.done, bus_a.dec, bus_a.ovf);
      end
      @(negedge clk) RSTn = 1'b1;
      f = rand_frame();
      kick_a(f);
      wait_a(30);
      #3 RSTn = 1'b0;
      #1;
      n_cmp++;
      if ({bus_a.busy, bus_a.done, bus_a.ovf} !== '0 || bus_a.dec !== '0) begin
         n_bad++;
         $display("FAIL reset_async: busy=%b done=%b dec=%h ovf=%h want all 0", bus_a.busy, bus_a.done, bus_a.dec, bus_a.ovf);
      end
      @(negedge clk);
      @(negedge clk) RSTn = 1'b1;
   endtask

   task automatic test_defaults();
      logic [L*W-1:0]  f;
      logic [L*DW-1:0] lit;
      int vals[L] = '{0, 1, 9, 10, 99, 100, 999, 1000, 1023, 512};
`ifdef LZ_BLANK_EN
      logic [DW-1:0] want[L] = '{16'hFFF0, 16'hFFF1, 16'hFFF9, 16'hFF10, 16'hFF99,
                                 16'hF100, 16'hF999, 16'h1000, 16'h1023, 16'hF512};
`else
      logic [DW-1:0] want[L] = '{16'h0000, 16'h0001, 16'h0009, 16'h0010, 16'h0099,
                                 16'h0100, 16'h0999, 16'h1000, 16'h1023, 16'h0512};
`endif
      for (int i = 0; i < L; i++) begin
         f[W*i +: W]     = W'(vals[i]);
         lit[DW*i +: DW] = want[i];
      end
      build_exp(f);
      kick_a(f);
      wait_a(LAT + 5);
      n_cmp++;
      if (done_edge != LAT || done_cnt != 1) begin
         n_bad++;
         $display("FAIL defaults_latency: done at edge %0d count %0d, want edge %0d count 1", done_edge, done_cnt, LAT);
      end
      n_cmp++;
      if (bus_a.dec !== lit) begin
         n_bad++;
         $display("FAIL defaults_dec: got %h want %h", bus_a.dec, lit);
      end
      n_cmp++;
      if (bus_a.dec !== exp_dec || bus_a.ovf !== '0) begin
         n_bad++;
         $display("FAIL defaults_model: dec %h ovf %h want dec %h ovf 0", bus_a.dec, bus_a.ovf, exp_dec);
      end
   endtask

   task automatic test_busy_ignore();
      logic [L*W-1:0]  f1;
      logic [L*DW-1:0] prev_dec;
      logic [L-1:0]    prev_ovf;
      prev_dec = exp_dec;
      prev_ovf = exp_ovf;
      f1 = rand_frame();
      build_exp(f1);
      kick_a(f1);
      done_edge = -1;
      done_cnt  = 0;
      for (int e = 1; e <= LAT + 6; e++) begin
         @(posedge clk);
         #1;
         if (e == 5)  bus_a.bin = ~f1;
         if (e == 49) bus_a.start = 1'b1;
         if (e == 50) bus_a.start = 1'b0;
         if (e == 60) begin
            n_cmp++;
            if (bus_a.dec !== prev_dec || bus_a.ovf !== prev_ovf || bus_a.busy !== 1'b1) begin
               n_bad++;
               $display("FAIL busy_stable: dec %h ovf %h busy %b want dec %h ovf %h busy 1", bus_a.dec, bus_a.ovf, bus_a.busy, prev_dec, prev_ovf);
            end
         end
         if (bus_a.done === 1'b1) begin
            if (done_cnt == 0) done_edge = e;
            done_cnt++;
         end
      end
      n_cmp++;
      if (done_edge != LAT || done_cnt != 1 || bus_a.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_ignore_done: edge %0d count %0d busy %b want edge %0d count 1 busy 0", done_edge, done_cnt, bus_a.busy, LAT);
      end
      n_cmp++;
      if (bus_a.dec !== exp_dec || bus_a.ovf !== exp_ovf) begin
         n_bad++;
         $display("FAIL busy_ignore_snapshot: dec %h want %h", bus_a.dec, exp_dec);
      end
   endtask

   task automatic test_random();
      logic [L*W-1:0] f;
      for (int r = 0; r < 4; r++) begin
         f = rand_frame();
         build_exp(f);
         kick_a(f);
         wait_a(LAT + 3);
         n_cmp++;
         if (done_edge != LAT || done_cnt != 1) begin
            n_bad++;
            $display("FAIL random_latency[%0d]: edge %0d count %0d want %0d/1", r, done_edge, done_cnt, LAT);
         end
         n_cmp++;
         if (bus_a.dec !== exp_dec || bus_a.ovf !== exp_ovf) begin
            n_bad++;
            $display("FAIL random_dec[%0d]: dec %h ovf %h want dec %h ovf %h", r, bus_a.dec, bus_a.ovf, exp_dec, exp_ovf);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [L*W-1:0]  f1, f2;
      logic [L*DW-1:0] e1, e2;
      int edges[2];
      f1 = rand_frame();
      f2 = rand_frame();
      build_exp(f2);
      e2 = exp_dec;
      build_exp(f1);
      e1 = exp_dec;
      edges = '{-1, -1};
      done_cnt = 0;
      @(negedge clk);
      bus_a.bin   = f1;
      bus_a.start = 1'b1;
      @(posedge clk);
      #1 bus_a.bin = f2;
      for (int e = 1; e <= 2*LAT + 6; e++) begin
         @(posedge clk);
         #1;
         if (e == LAT + 1) bus_a.start = 1'b0;
         if (bus_a.done === 1'b1) begin
            if (done_cnt < 2) edges[done_cnt] = e;
            n_cmp++;
            if (bus_a.dec !== (done_cnt == 0 ? e1 : e2)) begin
               n_bad++;
               $display("FAIL b2b_dec[%0d]: got %h want %h", done_cnt, bus_a.dec, (done_cnt == 0 ? e1 : e2));
            end
            done_cnt++;
         end
      end
      exp_dec = e2;
      n_cmp++;
      if (done_cnt != 2 || edges[0] != LAT || edges[1] != 2*LAT + 1) begin
         n_bad++;
         $display("FAIL b2b_timing: count %0d edges %0d,%0d want 2 at %0d,%0d", done_cnt, edges[0], edges[1], LAT, 2*LAT + 1);
      end
   endtask

   task automatic test_abort();
      logic [L*W-1:0] f;
      f = rand_frame();
      kick_a(f);
      wait_a(59);
      @(posedge clk);
      #2 RSTn = 1'b0;
      #1;
      n_cmp++;
      if (bus_a.busy !== 1'b0 || bus_a.dec !== '0 || bus_a.ovf !== '0) begin
         n_bad++;
         $display("FAIL abort_clear: busy %b dec %h ovf %h want 0", bus_a.busy, bus_a.dec, bus_a.ovf);
      end
      @(negedge clk);
      @(negedge clk) RSTn = 1'b1;
      wait_a(LAT + 10);
      n_cmp++;
      if (done_cnt != 0 || bus_a.dec !== '0 || bus_a.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_discard: done count %0d dec %h busy %b want 0", done_cnt, bus_a.dec, bus_a.busy);
      end
      f = rand_frame();
      build_exp(f);
      kick_a(f);
      wait_a(LAT + 3);
      n_cmp++;
      if (done_edge != LAT || bus_a.dec !== exp_dec || bus_a.ovf !== exp_ovf) begin
         n_bad++;
         $display("FAIL abort_recover: edge %0d dec %h want edge %0d dec %h", done_edge, bus_a.dec, LAT, exp_dec);
      end
   endtask

   task automatic test_d3();
      logic [L3*W-1:0]   f;
      logic [L3*DW3-1:0] lit;
`ifdef LZ_BLANK_EN
      lit = 24'h999_F23;
`else
      lit = 24'h999_023;
`endif
      f = {10'd999, 10'd1023};
      kick_b(f);
      wait_b(LAT3 + 3);
      n_cmp++;
      if (done_edge != LAT3 || bus_b.dec !== lit || bus_b.ovf !== 2'b01) begin
         n_bad++;
         $display("FAIL d3_fixed: edge %0d dec %h ovf %b want edge %0d dec %h ovf 01", done_edge, bus_b.dec, bus_b.ovf, LAT3, lit);
      end
      for (int r = 0; r < 4; r++) begin
         f = {W'($urandom_range(900, 1023)), W'($urandom_range(0, 1023))};
         build_exp_b(f);
         kick_b(f);
         wait_b(LAT3 + 3);
         n_cmp++;
         if (done_cnt != 1 || bus_b.dec !== exp_dec_b || bus_b.ovf !== exp_ovf_b) begin
            n_bad++;
            $display("FAIL d3_random[%0d]: count %0d dec %h ovf %b want dec %h ovf %b", r, done_cnt, bus_b.dec, bus_b.ovf, exp_dec_b, exp_ovf_b);
         end
      end
   endtask

   task automatic test_blank();
      logic [L*W-1:0] f;
      logic [4*DW-1:0] lit;
`ifdef LZ_BLANK_EN
      lit = {16'h1000, 16'hFF40, 16'hFFF7, 16'hFFF0};
`else
      lit = {16'h1000, 16'h0040, 16'h0007, 16'h0000};
`endif
      f = rand_frame();
      f[4*W-1:0] = {10'd1000, 10'd40, 10'd7, 10'd0};
      build_exp(f);
      kick_a(f);
      wait_a(LAT + 3);
      n_cmp++;
      if (bus_a.dec[4*DW-1:0] !== lit) begin
         n_bad++;
         $display("FAIL blank_fixed: got %h want %h", bus_a.dec[4*DW-1:0], lit);
      end
      n_cmp++;
      if (bus_a.dec !== exp_dec || bus_a.ovf !== exp_ovf) begin
         n_bad++;
         $display("FAIL blank_model: dec %h want %h", bus_a.dec, exp_dec);
      end
   endtask

   initial begin
      bus_a.start = 1'b0;
      bus_a.bin   = '0;
      bus_b.start = 1'b0;
      bus_b.bin   = '0;
      exp_dec     = '0;
      exp_ovf     = '0;
      test_reset();
      test_defaults();
      test_busy_ignore();
      test_random();
      test_back_to_back();
      test_abort();
      test_d3();
      test_blank();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
